memory_stage: RTL and testbench

// - Pipeline MEM stage. Consumes the execute->memory bundle (alu_result, rs2_data, opcode, funct3, rd)

---
 rtl/memory_stage.sv | 218 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage with a variable-latency data-memory port and a registered writeback output.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module memory_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  em_valid,
    output logic                  em_ready,
    input  logic [DATA_WIDTH-1:0] em_alu_result,
    input  logic [DATA_WIDTH-1:0] em_rs2_data,
    input  logic [6:0]            em_opcode,
    input  logic [2:0]            em_funct3,
    input  logic [4:0]            em_rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  mw_valid,
    input  logic                  mw_ready,
    output logic [DATA_WIDTH-1:0] mw_result,
    output logic [4:0]            mw_rd,
    output logic                  mw_reg_write,
    output logic                  mw_misalign
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        OUT
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [4:0]            rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  misalign_q, misalign_d;
    logic                  load_q, load_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;

    logic                  acceptOp;
    logic                  isLoad;
    logic                  isStore;
    logic                  isBranch;
    logic                  isMem;
    logic                  misaligned;
    logic [1:0]            emOff;
    logic [3:0]            stBe;
    logic [DATA_WIDTH-1:0] stWdata;
    logic [7:0]            laneByte;
    logic [15:0]           laneHalf;
    logic [DATA_WIDTH-1:0] loadData;

    assign isLoad   = (em_opcode == OP_LOAD);
    assign isStore  = (em_opcode == OP_STORE);
    assign isBranch = (em_opcode == OP_BRANCH);
    assign isMem    = isLoad | isStore;
    assign emOff    = em_alu_result[1:0];

    assign em_ready = ~rst & ((state_q == IDLE) | ((state_q == OUT) & mw_ready));
    assign acceptOp = em_valid & em_ready;

`ifdef MEM_MISALIGN_TRAP_EN
    // funct3[1:0] encodes the access size; anything wider than a halfword is a word access.
    always_comb begin
        misaligned = 1'b0;
        if (isMem) begin
            if (em_funct3[1:0] == 2'b01) begin
                misaligned = emOff[0];
            end else if (em_funct3[1]) begin
                misaligned = |emOff;
            end
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        stBe    = 4'b1111;
        stWdata = em_rs2_data;
        case (em_funct3[1:0])
            2'b00: begin
                stBe    = 4'b0001 << emOff;
                stWdata = {(DATA_WIDTH/8){em_rs2_data[7:0]}};
            end
            2'b01: begin
                stBe    = 4'b0011 << {emOff[1], 1'b0};
                stWdata = {(DATA_WIDTH/16){em_rs2_data[15:0]}};
            end
            default: begin
                stBe    = 4'b1111;
                stWdata = em_rs2_data;
            end
        endcase
    end

    // Lane extraction uses the offset captured at accept, since the ALU bus has moved on by ack time.
    always_comb begin
        laneByte = dmem_rdata[{off_q, 3'b000} +: 8];
        laneHalf = dmem_rdata[{off_q[1], 4'b0000} +: 16];
        loadData = dmem_rdata;
        case (f3_q[1:0])
            2'b00: begin
                loadData = f3_q[2] ? {{(DATA_WIDTH-8){1'b0}}, laneByte}
                                   : {{(DATA_WIDTH-8){laneByte[7]}}, laneByte};
            end
            2'b01: begin
                loadData = f3_q[2] ? {{(DATA_WIDTH-16){1'b0}}, laneHalf}
                                   : {{(DATA_WIDTH-16){laneHalf[15]}}, laneHalf};
            end
            default: begin
                loadData = dmem_rdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        result_d    = result_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        misalign_d  = misalign_q;
        load_d      = load_q;
        f3_d        = f3_q;
        off_d       = off_q;

        if ((state_q == MEM) && dmem_ack) begin
            state_d = OUT;
            if (load_q) begin
                result_d = loadData;
            end
        end

        if ((state_q == OUT) && mw_ready) begin
            state_d = IDLE;
        end

        // Accept only happens in IDLE or on an OUT handshake, so it never collides with the MEM branch.
        if (acceptOp) begin
            rd_d        = em_rd;
            result_d    = em_alu_result;
            misalign_d  = misaligned;
            reg_write_d = ~(isStore | isBranch | (em_rd == 5'd0) | misaligned);
            load_d      = isLoad;
            f3_d        = em_funct3;
            off_d       = emOff;
            if (isMem && !misaligned) begin
                state_d = MEM;
                addr_d  = ADDR_WIDTH'({em_alu_result[DATA_WIDTH-1:2], 2'b00});
                we_d    = isStore;
                be_d    = stBe;
                wdata_d = stWdata;
            end else begin
                state_d = OUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            misalign_q  <= 1'b0;
            load_q      <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            misalign_q  <= misalign_d;
            load_q      <= load_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    assign dmem_req     = (state_q == MEM);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign mw_valid     = (state_q == OUT);
    assign mw_result    = result_q;
    assign mw_rd        = rd_q;
    assign mw_reg_write = reg_write_q;
    assign mw_misalign  = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and randomized checks of memory_stage against an arithmetic reference model.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_memory_stage;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADD    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        em_valid;
    logic        em_ready;
    logic [31:0] em_alu_result;
    logic [31:0] em_rs2_data;
    logic [6:0]  em_opcode;
    logic [2:0]  em_funct3;
    logic [4:0]  em_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mw_valid;
    logic        mw_ready;
    logic [31:0] mw_result;
    logic [4:0]  mw_rd;
    logic        mw_reg_write;
    logic        mw_misalign;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        readyAtAccept;
        logic        reqSeen;
        logic        unstable;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          latency;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
        logic        misalign;
        logic        reqAtOut;
        logic        validAfter;
    } obs_t;

    memory_stage dut (
        .clk          (clk),
        .rst          (rst),
        .em_valid     (em_valid),
        .em_ready     (em_ready),
        .em_alu_result(em_alu_result),
        .em_rs2_data  (em_rs2_data),
        .em_opcode    (em_opcode),
        .em_funct3    (em_funct3),
        .em_rd        (em_rd),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .mw_valid     (mw_valid),
        .mw_ready     (mw_ready),
        .mw_result    (mw_result),
        .mw_rd        (mw_rd),
        .mw_reg_write (mw_reg_write),
        .mw_misalign  (mw_misalign)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes, derived from funct3 alone.
    function automatic int model_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_misalign(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu);
`ifdef MEM_MISALIGN_TRAP_EN
        if (op != OP_LOAD && op != OP_STORE) return 1'b0;
        return (int'(alu[1:0]) % model_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata);
        int     size;
        int     off;
        longint span;
        longint v;
        size = model_size(f3);
        if (size == 4) return rdata;
        off  = int'(alu[1:0]);
        off  = off - (off % size);
        span = longint'(1) << (8 * size);
        v    = longint'(rdata >> (8 * off)) % span;
        if (f3[2] == 1'b0 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] alu);
        int size;
        int off;
        size = model_size(f3);
        off  = int'(alu[1:0]);
        if (size == 1) return 4'(1 << off);
        if (size == 2) return 4'(3 << (off - (off % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int size;
        size = model_size(f3);
        if (size == 1) return 32'(rs2[7:0]) * 32'h0101_0101;
        if (size == 2) return 32'(rs2[15:0]) * 32'h0001_0001;
        return rs2;
    endfunction

    // Drives one transaction, plays the memory responder, and records what the DUT did.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
                                 input int ackDelay, output obs_t o);
        int cyc;
        int reqCnt;
        @(negedge clk);
        em_valid = 1'b1; em_opcode = op; em_funct3 = f3; em_rd = rd;
        em_alu_result = alu; em_rs2_data = rs2; mw_ready = 1'b0; dmem_ack = 1'b0;
        o = '{default: '0};
        o.readyAtAccept = em_ready;
        @(negedge clk);
        em_valid = 1'b0;
        cyc = 1;
        reqCnt = 0;
        while (!mw_valid && cyc < 60) begin
            if (dmem_req) begin
                if (!o.reqSeen) begin
                    o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
                end else if (dmem_addr !== o.addr || dmem_be !== o.be || dmem_wdata !== o.wdata || dmem_we !== o.we) begin
                    o.unstable = 1'b1;
                end
                o.reqSeen = 1'b1;
                if (reqCnt == ackDelay) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
                reqCnt++;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            cyc++;
        end
        o.latency  = mw_valid ? cyc : -1;
        o.result   = mw_result;
        o.rd       = mw_rd;
        o.regWrite = mw_reg_write;
        o.misalign = mw_misalign;
        o.reqAtOut = dmem_req;
        mw_ready = 1'b1;
        @(negedge clk);
        o.validAfter = mw_valid;
        mw_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; em_valid = 1'b0; mw_ready = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        em_opcode = '0; em_funct3 = '0; em_rd = '0; em_alu_result = '0; em_rs2_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (em_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_em_ready: got %b want 0", em_ready); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_dmem_req: got %b want 0", dmem_req); end
        checks++; if (mw_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mw_valid: got %b want 0", mw_valid); end
        checks++; if ({mw_result, mw_rd, mw_reg_write, mw_misalign} !== 39'd0) begin errors++; $display("[TB] FAIL reset_mw_fields: got %h/%0d/%b/%b want zeros", mw_result, mw_rd, mw_reg_write, mw_misalign); end
        checks++; if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== 69'd0) begin errors++; $display("[TB] FAIL reset_dmem_fields: got %h/%b/%h/%b want zeros", dmem_addr, dmem_be, dmem_wdata, dmem_we); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (em_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b want 1", em_ready); end
    endtask

    task automatic test_alu();
        obs_t o;
        applyStimulus(OP_ADD, 3'd0, 5'd5, 32'h1234, $urandom, $urandom, 0, o);
        checks++; if (o.readyAtAccept !== 1'b1) begin errors++; $display("[TB] FAIL add_ready: got %b want 1", o.readyAtAccept); end
        checks++; if (o.latency != 1) begin errors++; $display("[TB] FAIL add_latency: got %0d want 1", o.latency); end
        checks++; if (o.result !== 32'h1234) begin errors++; $display("[TB] FAIL add_result: got %h want 00001234", o.result); end
        checks++; if (o.rd !== 5'd5 || o.regWrite !== 1'b1) begin errors++; $display("[TB] FAIL add_rd_we: got rd %0d rw %b want rd 5 rw 1", o.rd, o.regWrite); end
        checks++; if (o.reqSeen !== 1'b0) begin errors++; $display("[TB] FAIL add_no_req: got %b want 0", o.reqSeen); end
        checks++; if (o.validAfter !== 1'b0) begin errors++; $display("[TB] FAIL add_valid_clear: got %b want 0", o.validAfter); end
        applyStimulus(OP_BRANCH, 3'd1, 5'd3, 32'h55, $urandom, $urandom, 0, o);
        checks++; if (o.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL branch_rw: got %b want 0", o.regWrite); end
        applyStimulus(OP_IMM, 3'd0, 5'd0, 32'h77, $urandom, $urandom, 0, o);
        checks++; if (o.regWrite !== 1'b0 || o.result !== 32'h77) begin errors++; $display("[TB] FAIL rd0_rw: got rw %b res %h want rw 0 res 00000077", o.regWrite, o.result); end
    endtask

    task automatic test_store();
        obs_t o;
        applyStimulus(OP_STORE, 3'd0, 5'd9, 32'h103, 32'hAB, $urandom, 2, o);
        checks++; if (o.addr !== 32'h100 || o.we !== 1'b1) begin errors++; $display("[TB] FAIL sb_addr_we: got %h/%b want 00000100/1", o.addr, o.we); end
        checks++; if (o.be !== 4'b1000) begin errors++; $display("[TB] FAIL sb_be: got %b want 1000", o.be); end
        checks++; if (o.wdata !== 32'hABABABAB) begin errors++; $display("[TB] FAIL sb_wdata: got %h want abababab", o.wdata); end
        checks++; if (o.latency != 4 || o.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL sb_done: got lat %0d rw %b want lat 4 rw 0", o.latency, o.regWrite); end
        checks++; if (o.unstable !== 1'b0 || o.reqAtOut !== 1'b0) begin errors++; $display("[TB] FAIL sb_req_hold: got unstable %b req %b want 0/0", o.unstable, o.reqAtOut); end
        applyStimulus(OP_STORE, 3'd1, 5'd9, 32'h106, 32'h1234CAFE, $urandom, 1, o);
        checks++; if (o.be !== 4'b1100 || o.wdata !== 32'hCAFECAFE) begin errors++; $display("[TB] FAIL sh_lanes: got %b/%h want 1100/cafecafe", o.be, o.wdata); end
        applyStimulus(OP_STORE, 3'd2, 5'd9, 32'h200, 32'h89ABCDEF, $urandom, 0, o);
        checks++; if (o.be !== 4'b1111 || o.wdata !== 32'h89ABCDEF || o.addr !== 32'h200) begin errors++; $display("[TB] FAIL sw_lanes: got %b/%h/%h want 1111/89abcdef/00000200", o.be, o.wdata, o.addr); end
    endtask

    task automatic test_load();
        obs_t o;
        applyStimulus(OP_LOAD, 3'd0, 5'd7, 32'h101, $urandom, 32'h0000_8000, 0, o);
        checks++; if (o.result !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_result: got %h want ffffff80", o.result); end
        checks++; if (o.latency != 2 || o.regWrite !== 1'b1 || o.we !== 1'b0 || o.addr !== 32'h100) begin errors++; $display("[TB] FAIL lb_access: got lat %0d rw %b we %b addr %h want 2/1/0/00000100", o.latency, o.regWrite, o.we, o.addr); end
        applyStimulus(OP_LOAD, 3'd4, 5'd7, 32'h101, $urandom, 32'h0000_8000, 1, o);
        checks++; if (o.result !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_result: got %h want 00000080", o.result); end
        applyStimulus(OP_LOAD, 3'd1, 5'd7, 32'h102, $urandom, 32'h8001_0000, 3, o);
        checks++; if (o.result !== 32'hFFFF8001 || o.latency != 5) begin errors++; $display("[TB] FAIL lh_result: got %h lat %0d want ffff8001 lat 5", o.result, o.latency); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        em_valid = 1'b1; em_opcode = OP_ADD; em_funct3 = 3'd0; em_rd = 5'd1; em_alu_result = 32'h11; mw_ready = 1'b0;
        @(negedge clk);
        em_rd = 5'd2; em_alu_result = 32'h22;
        for (int i = 0; i < 4; i++) begin
            checks++; if (em_ready !== 1'b0 || mw_valid !== 1'b1 || mw_result !== 32'h11 || mw_rd !== 5'd1) begin errors++; $display("[TB] FAIL stall_hold_%0d: got ready %b valid %b res %h rd %0d want 0/1/00000011/1", i, em_ready, mw_valid, mw_result, mw_rd); end
            @(negedge clk);
        end
        mw_ready = 1'b1;
        #1;
        checks++; if (em_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready: got %b want 1", em_ready); end
        @(negedge clk);
        em_valid = 1'b0;
        checks++; if (mw_valid !== 1'b1 || mw_result !== 32'h22 || mw_rd !== 5'd2) begin errors++; $display("[TB] FAIL b2b_no_bubble: got valid %b res %h rd %0d want 1/00000022/2", mw_valid, mw_result, mw_rd); end
        @(negedge clk);
        checks++; if (mw_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b want 0", mw_valid); end
        mw_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        em_valid = 1'b1; em_opcode = OP_LOAD; em_funct3 = 3'd2; em_rd = 5'd4; em_alu_result = 32'h40; mw_ready = 1'b1;
        @(negedge clk);
        em_valid = 1'b0;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_req_up: got %b want 1", dmem_req); end
        rst = 1'b1;
        #1;
        checks++; if (em_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready_in_reset: got %b want 0", em_ready); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (dmem_req !== 1'b0 || mw_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_drop: got req %b valid %b want 0/0", dmem_req, mw_valid); end
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        @(negedge clk);
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mw_valid !== 1'b0 || dmem_req !== 1'b0 || em_ready !== 1'b1) begin errors++; $display("[TB] FAIL late_ack_%0d: got valid %b req %b ready %b want 0/0/1", i, mw_valid, dmem_req, em_ready); end
            @(negedge clk);
        end
        mw_ready = 1'b0;
    endtask

    task automatic test_misalign();
        obs_t o;
        applyStimulus(OP_LOAD, 3'd2, 5'd6, 32'h102, $urandom, 32'hDEADBEEF, 1, o);
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (o.reqSeen !== 1'b0 || o.latency != 1) begin errors++; $display("[TB] FAIL lw_mis_noreq: got req %b lat %0d want 0/1", o.reqSeen, o.latency); end
        checks++; if (o.misalign !== 1'b1 || o.regWrite !== 1'b0 || o.result !== 32'h102) begin errors++; $display("[TB] FAIL lw_mis_out: got mis %b rw %b res %h want 1/0/00000102", o.misalign, o.regWrite, o.result); end
`else
        checks++; if (o.reqSeen !== 1'b1 || o.addr !== 32'h100) begin errors++; $display("[TB] FAIL lw_unal_addr: got req %b addr %h want 1/00000100", o.reqSeen, o.addr); end
        checks++; if (o.misalign !== 1'b0 || o.regWrite !== 1'b1 || o.result !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_unal_out: got mis %b rw %b res %h want 0/1/deadbeef", o.misalign, o.regWrite, o.result); end
`endif
    endtask

    task automatic test_random();
        obs_t        o;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, rs2, rdata;
        int          ack;
        logic        isSt, isLd, mis, expReq, expRw;
        logic [31:0] expRes;
        int          expLat;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       op = OP_LOAD;
                1:       op = OP_STORE;
                2:       op = OP_BRANCH;
                3:       op = OP_ADD;
                default: op = OP_IMM;
            endcase
            case ($urandom_range(0, 4))
                0:       f3 = 3'd0;
                1:       f3 = 3'd1;
                2:       f3 = 3'd2;
                3:       f3 = (op == OP_STORE) ? 3'd0 : 3'd4;
                default: f3 = (op == OP_STORE) ? 3'd1 : 3'd5;
            endcase
            rd    = 5'($urandom_range(0, 31));
            alu   = $urandom;
            rs2   = $urandom;
            rdata = $urandom;
            ack   = $urandom_range(0, 3);
            applyStimulus(op, f3, rd, alu, rs2, rdata, ack, o);
            isSt   = (op == OP_STORE);
            isLd   = (op == OP_LOAD);
            mis    = model_misalign(op, f3, alu);
            expReq = (isSt || isLd) && !mis;
            expLat = expReq ? ack + 2 : 1;
            expRes = (isLd && !mis) ? model_load(f3, alu, rdata) : alu;
            expRw  = !(isSt || op == OP_BRANCH || rd == 5'd0 || mis);
            checks++; if (o.latency != expLat || o.reqSeen !== expReq) begin errors++; $display("[TB] FAIL rnd%0d_timing: got lat %0d req %b want lat %0d req %b", i, o.latency, o.reqSeen, expLat, expReq); end
            checks++; if (o.result !== expRes || o.rd !== rd) begin errors++; $display("[TB] FAIL rnd%0d_result: op %b f3 %0d alu %h rdata %h got %h rd %0d want %h rd %0d", i, op, f3, alu, rdata, o.result, o.rd, expRes, rd); end
            checks++; if (o.regWrite !== expRw || o.misalign !== mis) begin errors++; $display("[TB] FAIL rnd%0d_flags: got rw %b mis %b want rw %b mis %b", i, o.regWrite, o.misalign, expRw, mis); end
            if (expReq) begin
                checks++; if (o.addr !== (alu & 32'hFFFF_FFFC) || o.we !== isSt || o.unstable !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_access: got addr %h we %b unstable %b want addr %h we %b", i, o.addr, o.we, o.unstable, alu & 32'hFFFF_FFFC, isSt); end
            end
            if (expReq && isSt) begin
                checks++; if (o.be !== model_be(f3, alu) || o.wdata !== model_wdata(f3, rs2)) begin errors++; $display("[TB] FAIL rnd%0d_lanes: got be %b wdata %h want be %b wdata %h", i, o.be, o.wdata, model_be(f3, alu), model_wdata(f3, rs2)); end
            end
        end
    endtask

    task automatic checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        $display("[TB] starting memory_stage bench");
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        test_random();
        checkOutput();
        $finish;
    end

endmodule
